// File: rtl/hacd_pkg.sv
// Shared HACD types for the page-read path: AXI read packets, record-header
// layout, decompression-manager state encoding and table-update packets.
package hacd_pkg;

   localparam int HACD_AXI4_ADDR_WIDTH = 64;
   localparam int HACD_AXI4_DATA_WIDTH = 512;
   localparam int ATT_ENTRY_MAX        = 1024;
   localparam int ATT_ID_W             = $clog2(ATT_ENTRY_MAX);
   localparam int WAY_W                = HACD_AXI4_ADDR_WIDTH - 12;

   // Compressed-record header: payload size in bytes sits at the bottom of beat 0
   localparam int HDR_SIZE_LSB = 0;
   localparam int HDR_SIZE_W   = 14;

   typedef enum logic [3:0] {
      ST_IDLE      = 4'd0,
      ST_HDR_REQ   = 4'd1,
      ST_HDR_WAIT  = 4'd2,
      ST_PLD_REQ   = 4'd3,
      ST_PLD       = 4'd4,
      ST_START     = 4'd5,
      ST_WAIT_DC   = 4'd6,
      ST_ZSPG_REL  = 4'd7,
      ST_TOL_BUILD = 4'd8,
      ST_DONE      = 4'd9,
      ST_ERROR     = 4'd10
   } dc_state_e;

   typedef enum logic [1:0] {
      STS_INVALID = 2'd0,
      STS_UNCOMP  = 2'd1,
      STS_COMP    = 2'd2,
      STS_INCOMP  = 2'd3
   } att_sts_e;

   typedef struct packed {
      logic arready;
   } axi_rd_rdypkt_t;

   typedef struct packed {
      logic                            rvalid;
      logic                            rlast;
      logic [HACD_AXI4_DATA_WIDTH-1:0] rdata;
      logic [1:0]                      rresp;
   } axi_rd_resppkt_t;

   typedef struct packed {
      logic [HACD_AXI4_ADDR_WIDTH-1:0] addr;
      logic [7:0]                      arlen;
   } axi_rd_pld_t;

   // zs_release is the slot-release request bit ("release" is a reserved word)
   typedef struct packed {
      logic [HACD_AXI4_ADDR_WIDTH-1:0] cPage_byteStart;
      logic [HACD_AXI4_ADDR_WIDTH-1:0] iWay;
      logic                            zs_release;
   } iWayORcPagePkt_t;

   typedef struct packed {
      logic [WAY_W-1:0] way;
   } lst_entry_t;

   typedef struct packed {
      logic [ATT_ID_W-1:0] attEntryId;
      lst_entry_t          lstEntry;
      att_sts_e            ATT_STS;
      logic [7:0]          zpd_cnt;
      logic                tbl_update;
      logic                ATT_UPDATE_ONLY;
   } tol_updpkt_t;

endpackage

// File: rtl/hawk_cpage_fetch_ctr.sv
// Payload beat bookkeeping: converts the header size into a beat count and
// arlen, and counts accepted payload beats against it.
module hawk_cpage_fetch_ctr
   import hacd_pkg::*;
#(
   parameter int PAGE_BYTES = 4096
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic [HDR_SIZE_W-1:0] hdr_size,
   input  logic                  size_ld,
   input  logic                  beat_inc,
   output logic                  size_bad,
   output logic [7:0]            hdr_arlen,
   output logic                  last_ok
);

   logic [7:0] hdr_beats;
   logic [7:0] n_beats_q;
   logic [7:0] beat_cnt_q;

   // ceil(S/64); wraps only for sizes already rejected by size_bad
   assign hdr_beats = hdr_size[HDR_SIZE_W-1:6] + 8'(|hdr_size[5:0]);
   assign hdr_arlen = hdr_beats - 8'd1;
   assign size_bad  = (hdr_size == '0) || (hdr_size > HDR_SIZE_W'(PAGE_BYTES));
   assign last_ok   = (beat_cnt_q + 8'd1) == n_beats_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         n_beats_q  <= '0;
         beat_cnt_q <= '0;
      end else if (size_ld) begin
         n_beats_q  <= hdr_beats;
         beat_cnt_q <= '0;
      end else if (beat_inc) begin
         beat_cnt_q <= beat_cnt_q + 8'd1;
      end
   end

endmodule

// File: rtl/hawk_decomp_page_mngr.sv
// Decompression manager: fetches a compressed page record over AXI, feeds the
// decompressor, requests zspage slot release and builds the ATT/TOL update.
module hawk_decomp_page_mngr
   import hacd_pkg::*;
#(
   parameter int PAGE_BYTES = 4096,
   parameter int BEAT_BYTES = 64
) (
   input  logic                            clk_i,
   input  logic                            rst_ni,
   input  logic                            decomp_trigger,
   input  logic [HACD_AXI4_ADDR_WIDTH-1:0] decomp_cPage_byteStart,
   input  logic [HACD_AXI4_ADDR_WIDTH-1:0] decomp_freeWay,
   input  logic [ATT_ID_W-1:0]             p_attEntryId,
   input  axi_rd_rdypkt_t                  rd_rdypkt,
   input  axi_rd_resppkt_t                 rd_resppkt,
   input  logic                            rdfifo_full,
   input  logic                            decomp_done,
   input  logic                            zspg_updated,
   output axi_rd_pld_t                     p_decomp_axireq,
   output logic                            p_decomp_req_arvalid,
   output logic                            n_decomp_rready,
   output logic [HACD_AXI4_DATA_WIDTH-1:0] n_decomp_rdata,
   output logic                            decomp_start,
   output logic                            decomp_rdm_reset,
   output iWayORcPagePkt_t                 dc_iWayORcPagePkt,
   output tol_updpkt_t                     n_decomp_tol_updpkt,
   output logic                            decomp_mngr_done
);

   dc_state_e                       state_q, state_d;
   logic                            trig_q;
   logic                            drain_q, drain_set;
   logic [HACD_AXI4_ADDR_WIDTH-1:0] base_q;
   logic                            size_ld, beat_inc, size_bad, last_ok;
   logic [7:0]                      hdr_arlen;
   logic                            beat_acc, abortable, rd_outstanding;
   logic                            way_offs_unused;

   assign way_offs_unused = ^decomp_freeWay[11:0];

   hawk_cpage_fetch_ctr #(
      .PAGE_BYTES (PAGE_BYTES)
   ) u_fetch_ctr (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .hdr_size  (rd_resppkt.rdata[HDR_SIZE_LSB +: HDR_SIZE_W]),
      .size_ld   (size_ld),
      .beat_inc  (beat_inc),
      .size_bad  (size_bad),
      .hdr_arlen (hdr_arlen),
      .last_ok   (last_ok)
   );

   assign beat_acc       = rd_resppkt.rvalid && n_decomp_rready;
   assign n_decomp_rdata = (state_q == ST_PLD && beat_acc) ? rd_resppkt.rdata : '0;

   assign abortable = !(state_q inside {ST_IDLE, ST_DONE, ST_ERROR});
   // A read is in flight if we were waiting on data or the AR handshake just happened
   assign rd_outstanding = (state_q inside {ST_HDR_WAIT, ST_PLD}) ||
                           ((state_q inside {ST_HDR_REQ, ST_PLD_REQ}) && rd_rdypkt.arready);

   always_comb begin
      state_d         = state_q;
      n_decomp_rready = 1'b0;
      size_ld         = 1'b0;
      beat_inc        = 1'b0;
      drain_set       = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            n_decomp_rready = drain_q;
            if (decomp_trigger && !trig_q) state_d = ST_HDR_REQ;
         end
         ST_HDR_REQ: if (rd_rdypkt.arready) state_d = ST_HDR_WAIT;
         ST_HDR_WAIT: begin
            n_decomp_rready = 1'b1;
            if (rd_resppkt.rvalid) begin
               if (rd_resppkt.rresp != 2'd0) state_d = ST_ERROR;
               else if (rd_resppkt.rlast) begin
                  if (size_bad) state_d = ST_ERROR;
                  else begin
                     size_ld = 1'b1;
                     state_d = ST_PLD_REQ;
                  end
               end
            end
         end
         ST_PLD_REQ: if (rd_rdypkt.arready) state_d = ST_PLD;
         ST_PLD: begin
            n_decomp_rready = !rdfifo_full;
            if (beat_acc) begin
               beat_inc = 1'b1;
               if (rd_resppkt.rresp != 2'd0) state_d = ST_ERROR;
               else if (rd_resppkt.rlast) state_d = last_ok ? ST_START : ST_ERROR;
            end
         end
         ST_START:     state_d = ST_WAIT_DC;
         ST_WAIT_DC:   if (decomp_done) state_d = ST_ZSPG_REL;
         ST_ZSPG_REL:  if (zspg_updated) state_d = ST_TOL_BUILD;
         ST_TOL_BUILD: state_d = ST_DONE;
         ST_DONE:      if (!decomp_trigger) state_d = ST_IDLE;
         ST_ERROR:     n_decomp_rready = 1'b1;
         default:      state_d = ST_IDLE;
      endcase
      if (abortable && !decomp_trigger) begin
         state_d   = ST_IDLE;
         size_ld   = 1'b0;
         drain_set = rd_outstanding && !(beat_acc && rd_resppkt.rlast);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= ST_IDLE;
         trig_q  <= 1'b0;
         drain_q <= 1'b0;
      end else begin
         state_q <= state_d;
         trig_q  <= decomp_trigger;
         drain_q <= drain_set ||
                    (drain_q && !(state_q == ST_IDLE && rd_resppkt.rvalid && rd_resppkt.rlast));
      end
   end

   always_ff @(posedge clk_i) begin
      if (state_q == ST_IDLE && state_d == ST_HDR_REQ) base_q <= decomp_cPage_byteStart;
   end

   // Registered outputs are derived from the next state so they line up with it
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         p_decomp_axireq      <= '0;
         p_decomp_req_arvalid <= 1'b0;
         decomp_start         <= 1'b0;
         decomp_rdm_reset     <= 1'b0;
         dc_iWayORcPagePkt    <= '0;
         n_decomp_tol_updpkt  <= '0;
         decomp_mngr_done     <= 1'b0;
      end else begin
         p_decomp_req_arvalid <= (state_d == ST_HDR_REQ) || (state_d == ST_PLD_REQ);
         decomp_rdm_reset     <= (state_q == ST_IDLE) && (state_d == ST_HDR_REQ);
         decomp_start         <= (state_d == ST_START);
         decomp_mngr_done     <= (state_d == ST_DONE) && (state_q != ST_DONE);

         if (state_d == ST_HDR_REQ) begin
            if (state_q == ST_IDLE) begin
               p_decomp_axireq.addr  <= decomp_cPage_byteStart;
               p_decomp_axireq.arlen <= 8'd0;
            end
         end else if (state_d == ST_PLD_REQ) begin
            if (state_q == ST_HDR_WAIT) begin
               p_decomp_axireq.addr  <= base_q + HACD_AXI4_ADDR_WIDTH'(BEAT_BYTES);
               p_decomp_axireq.arlen <= hdr_arlen;
            end
         end else begin
            p_decomp_axireq <= '0;
         end

         if (state_d == ST_ZSPG_REL) begin
            dc_iWayORcPagePkt.cPage_byteStart <= base_q;
            dc_iWayORcPagePkt.iWay            <= '0;
            dc_iWayORcPagePkt.zs_release      <= 1'b1;
         end else begin
            dc_iWayORcPagePkt <= '0;
         end

         if (state_d == ST_TOL_BUILD) begin
            n_decomp_tol_updpkt.attEntryId      <= p_attEntryId;
            n_decomp_tol_updpkt.lstEntry.way    <= decomp_freeWay[HACD_AXI4_ADDR_WIDTH-1:12];
            n_decomp_tol_updpkt.ATT_STS         <= STS_UNCOMP;
            n_decomp_tol_updpkt.zpd_cnt         <= '0;
            n_decomp_tol_updpkt.tbl_update      <= 1'b0;
            n_decomp_tol_updpkt.ATT_UPDATE_ONLY <= 1'b0;
         end else if (state_q == ST_IDLE && state_d == ST_HDR_REQ) begin
            n_decomp_tol_updpkt <= '0;
         end
      end
   end

endmodule

// File: tb/tb_hawk_decomp_page_mngr.sv
// Directed bench for hawk_decomp_page_mngr: normal restore, full-page fetch
// with FIFO backpressure, read errors, trigger abort and async reset.
module tb_hawk_decomp_page_mngr;
   import hacd_pkg::*;

   logic                            clk_i = 1'b0;
   logic                            rst_ni;
   logic                            decomp_trigger;
   logic [HACD_AXI4_ADDR_WIDTH-1:0] decomp_cPage_byteStart;
   logic [HACD_AXI4_ADDR_WIDTH-1:0] decomp_freeWay;
   logic [ATT_ID_W-1:0]             p_attEntryId;
   axi_rd_rdypkt_t                  rd_rdypkt;
   axi_rd_resppkt_t                 rd_resppkt;
   logic                            rdfifo_full;
   logic                            decomp_done;
   logic                            zspg_updated;
   axi_rd_pld_t                     p_decomp_axireq;
   logic                            p_decomp_req_arvalid;
   logic                            n_decomp_rready;
   logic [HACD_AXI4_DATA_WIDTH-1:0] n_decomp_rdata;
   logic                            decomp_start;
   logic                            decomp_rdm_reset;
   iWayORcPagePkt_t                 dc_iWayORcPagePkt;
   tol_updpkt_t                     n_decomp_tol_updpkt;
   logic                            decomp_mngr_done;

   int checks = 0;
   int passes = 0;
   int ar_cnt = 0;

   always #5 clk_i = ~clk_i;

   hawk_decomp_page_mngr dut (
      .clk_i                  (clk_i),
      .rst_ni                 (rst_ni),
      .decomp_trigger         (decomp_trigger),
      .decomp_cPage_byteStart (decomp_cPage_byteStart),
      .decomp_freeWay         (decomp_freeWay),
      .p_attEntryId           (p_attEntryId),
      .rd_rdypkt              (rd_rdypkt),
      .rd_resppkt             (rd_resppkt),
      .rdfifo_full            (rdfifo_full),
      .decomp_done            (decomp_done),
      .zspg_updated           (zspg_updated),
      .p_decomp_axireq        (p_decomp_axireq),
      .p_decomp_req_arvalid   (p_decomp_req_arvalid),
      .n_decomp_rready        (n_decomp_rready),
      .n_decomp_rdata         (n_decomp_rdata),
      .decomp_start           (decomp_start),
      .decomp_rdm_reset       (decomp_rdm_reset),
      .dc_iWayORcPagePkt      (dc_iWayORcPagePkt),
      .n_decomp_tol_updpkt    (n_decomp_tol_updpkt),
      .decomp_mngr_done       (decomp_mngr_done)
   );

   always @(posedge clk_i) if (rst_ni && p_decomp_req_arvalid && rd_rdypkt.arready) ar_cnt++;

   task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   function automatic logic [511:0] pat(input int k);
      logic [31:0] w;
      w = 32'hC0DE_0000 + 32'(k);
      return {16{w}};
   endfunction

   task automatic hdr(input int s);
      rd_resppkt        = '0;
      rd_resppkt.rvalid = 1'b1;
      rd_resppkt.rlast  = 1'b1;
      rd_resppkt.rdata[13:0] = 14'(s);
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk({tag, "_arvalid"}, 512'(p_decomp_req_arvalid), '0);
      chk({tag, "_axireq"},  512'(p_decomp_axireq), '0);
      chk({tag, "_rready"},  512'(n_decomp_rready), '0);
      chk({tag, "_rdata"},   n_decomp_rdata, '0);
      chk({tag, "_start"},   512'(decomp_start), '0);
      chk({tag, "_rdm"},     512'(decomp_rdm_reset), '0);
      chk({tag, "_relpkt"},  512'(dc_iWayORcPagePkt), '0);
      chk({tag, "_tolpkt"},  512'(n_decomp_tol_updpkt), '0);
      chk({tag, "_done"},    512'(decomp_mngr_done), '0);
   endtask

   localparam logic [63:0] BASE = 64'h0000_0000_8000_1040;
   localparam logic [63:0] FWAY = 64'h0000_0012_3456_7000;

   initial begin
      int k;
      logic acc;
      iWayORcPagePkt_t exp_rel;
      tol_updpkt_t exp_tol;

      rst_ni = 1'b0;
      decomp_trigger = 1'b0;
      decomp_cPage_byteStart = BASE;
      decomp_freeWay = FWAY;
      p_attEntryId = 10'h155;
      rd_rdypkt = '0;
      rd_resppkt = '0;
      rdfifo_full = 1'b0;
      decomp_done = 1'b0;
      zspg_updated = 1'b0;
      repeat (3) step();
      chk_idle_outputs("reset");

      // ---- Op 1: S=200, arready stalled 10 cycles in HDR_REQ ----
      rst_ni = 1'b1;
      step();
      decomp_trigger = 1'b1;
      step();
      chk("op1_rdm", 512'(decomp_rdm_reset), 512'(1));
      chk("op1_hdr_arvalid", 512'(p_decomp_req_arvalid), 512'(1));
      chk("op1_hdr_addr", 512'(p_decomp_axireq.addr), 512'(BASE));
      chk("op1_hdr_arlen", 512'(p_decomp_axireq.arlen), '0);
      for (int i = 0; i < 10; i++) begin
         step();
         chk("op1_stall_arvalid", 512'(p_decomp_req_arvalid), 512'(1));
         chk("op1_stall_addr", 512'(p_decomp_axireq.addr), 512'(BASE));
         chk("op1_stall_rdm", 512'(decomp_rdm_reset), '0);
      end
      rd_rdypkt.arready = 1'b1;
      step();
      rd_rdypkt.arready = 1'b0;
      chk("op1_arvalid_drop", 512'(p_decomp_req_arvalid), '0);
      hdr(200);
      #1;
      chk("op1_hdr_rready", 512'(n_decomp_rready), 512'(1));
      chk("op1_hdr_not_fwd", n_decomp_rdata, '0);
      step();
      rd_resppkt = '0;
      chk("op1_pld_arvalid", 512'(p_decomp_req_arvalid), 512'(1));
      chk("op1_pld_addr", 512'(p_decomp_axireq.addr), 512'(64'h0000_0000_8000_1080));
      chk("op1_pld_arlen", 512'(p_decomp_axireq.arlen), 512'(3));
      rd_rdypkt.arready = 1'b1;
      step();
      rd_rdypkt.arready = 1'b0;
      chk("op1_pld_arvalid_drop", 512'(p_decomp_req_arvalid), '0);
      for (int i = 0; i < 4; i++) begin
         rd_resppkt.rvalid = 1'b1;
         rd_resppkt.rdata  = pat(i);
         rd_resppkt.rlast  = (i == 3);
         #1;
         chk("op1_beat_rready", 512'(n_decomp_rready), 512'(1));
         chk("op1_beat_data", n_decomp_rdata, pat(i));
         step();
      end
      rd_resppkt = '0;
      chk("op1_start", 512'(decomp_start), 512'(1));
      step();
      chk("op1_start_pulse", 512'(decomp_start), '0);
      zspg_updated = 1'b1;
      step();
      zspg_updated = 1'b0;
      chk("op1_zspg_ignored", 512'(dc_iWayORcPagePkt), '0);
      decomp_done = 1'b1;
      step();
      decomp_done = 1'b0;
      exp_rel.cPage_byteStart = BASE;
      exp_rel.iWay = '0;
      exp_rel.zs_release = 1'b1;
      chk("op1_relpkt", 512'(dc_iWayORcPagePkt), 512'(exp_rel));
      step();
      chk("op1_relpkt_held", 512'(dc_iWayORcPagePkt), 512'(exp_rel));
      zspg_updated = 1'b1;
      step();
      zspg_updated = 1'b0;
      exp_tol.attEntryId = 10'h155;
      exp_tol.lstEntry.way = 52'h0_0000_0012_3456_7;
      exp_tol.ATT_STS = STS_UNCOMP;
      exp_tol.zpd_cnt = 8'd0;
      exp_tol.tbl_update = 1'b0;
      exp_tol.ATT_UPDATE_ONLY = 1'b0;
      chk("op1_tolpkt", 512'(n_decomp_tol_updpkt), 512'(exp_tol));
      chk("op1_done_early", 512'(decomp_mngr_done), '0);
      step();
      chk("op1_done", 512'(decomp_mngr_done), 512'(1));
      step();
      chk("op1_done_pulse", 512'(decomp_mngr_done), '0);
      decomp_trigger = 1'b0;
      step();
      chk("op1_ar_count", 512'(ar_cnt), 512'(2));

      // ---- Op 2: S=4096 with FIFO full toggling; abort in WAIT_DC ----
      decomp_trigger = 1'b1;
      step();
      chk("op2_rdm", 512'(decomp_rdm_reset), 512'(1));
      rd_rdypkt.arready = 1'b1;
      step();
      rd_rdypkt.arready = 1'b0;
      hdr(4096);
      step();
      rd_resppkt = '0;
      chk("op2_arlen", 512'(p_decomp_axireq.arlen), 512'(63));
      rd_rdypkt.arready = 1'b1;
      step();
      rd_rdypkt.arready = 1'b0;
      k = 0;
      for (int cyc = 0; cyc < 300 && k < 64; cyc++) begin
         rdfifo_full = cyc[0];
         rd_resppkt.rvalid = 1'b1;
         rd_resppkt.rdata  = pat(k);
         rd_resppkt.rlast  = (k == 63);
         #1;
         chk("op2_rready_tracks", 512'(n_decomp_rready), 512'(!rdfifo_full));
         acc = n_decomp_rready;
         if (acc) chk("op2_beat_data", n_decomp_rdata, pat(k));
         step();
         if (acc) k++;
         if (k < 64) chk("op2_no_early_start", 512'(decomp_start), '0);
      end
      rd_resppkt = '0;
      rdfifo_full = 1'b0;
      chk("op2_beats", 512'(k), 512'(64));
      chk("op2_start", 512'(decomp_start), 512'(1));
      step();
      decomp_trigger = 1'b0;
      step();
      decomp_done = 1'b1;
      step();
      decomp_done = 1'b0;
      chk("op2_abort_relpkt", 512'(dc_iWayORcPagePkt), '0);
      chk("op2_abort_arvalid", 512'(p_decomp_req_arvalid), '0);
      decomp_trigger = 1'b1;
      step();
      chk("op3_restart_rdm", 512'(decomp_rdm_reset), 512'(1));
      chk("op3_restart_arvalid", 512'(p_decomp_req_arvalid), 512'(1));

      // ---- Op 3: S=130, rresp=2 on payload beat 1 ----
      rd_rdypkt.arready = 1'b1;
      step();
      rd_rdypkt.arready = 1'b0;
      hdr(130);
      step();
      rd_resppkt = '0;
      chk("op3_arlen", 512'(p_decomp_axireq.arlen), 512'(2));
      rd_rdypkt.arready = 1'b1;
      step();
      rd_rdypkt.arready = 1'b0;
      rd_resppkt.rvalid = 1'b1;
      rd_resppkt.rdata = pat(0);
      step();
      rd_resppkt.rdata = pat(1);
      rd_resppkt.rresp = 2'd2;
      step();
      rd_resppkt = '0;
      #1;
      chk("op3_err_drain", 512'(n_decomp_rready), 512'(1));
      for (int i = 0; i < 3; i++) begin
         step();
         chk("op3_err_no_done", 512'(decomp_mngr_done), '0);
      end
      decomp_trigger = 1'b0;
      step();
      decomp_trigger = 1'b1;
      step();
      chk("op3_err_sticky_rdm", 512'(decomp_rdm_reset), '0);
      chk("op3_err_sticky_arvalid", 512'(p_decomp_req_arvalid), '0);
      chk("op3_err_sticky_rready", 512'(n_decomp_rready), 512'(1));
      #2;
      rst_ni = 1'b0;
      decomp_trigger = 1'b0;
      #1;
      chk_idle_outputs("err_reset");
      step();
      rst_ni = 1'b1;
      step();

      // ---- Op 4: S=0 is rejected ----
      decomp_trigger = 1'b1;
      step();
      rd_rdypkt.arready = 1'b1;
      step();
      rd_rdypkt.arready = 1'b0;
      hdr(0);
      step();
      rd_resppkt = '0;
      #1;
      chk("op4_s0_no_pld_req", 512'(p_decomp_req_arvalid), '0);
      chk("op4_s0_error_drain", 512'(n_decomp_rready), 512'(1));
      rst_ni = 1'b0;
      decomp_trigger = 1'b0;
      step();
      rst_ni = 1'b1;
      step();

      // ---- Op 5: S=64, async reset in the middle of PLD ----
      decomp_trigger = 1'b1;
      step();
      rd_rdypkt.arready = 1'b1;
      step();
      rd_rdypkt.arready = 1'b0;
      hdr(64);
      step();
      rd_resppkt = '0;
      chk("op5_arlen", 512'(p_decomp_axireq.arlen), '0);
      chk("op5_addr", 512'(p_decomp_axireq.addr), 512'(64'h0000_0000_8000_1080));
      rd_rdypkt.arready = 1'b1;
      step();
      rd_rdypkt.arready = 1'b0;
      rd_resppkt.rvalid = 1'b1;
      rd_resppkt.rlast = 1'b1;
      rd_resppkt.rdata = pat(7);
      #1;
      chk("op5_beat_data", n_decomp_rdata, pat(7));
      #1;
      rst_ni = 1'b0;
      #1;
      chk_idle_outputs("mid_pld_reset");

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
